// File: rtl/abc_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// abc_rr_arbiter_pkg
// Shared definitions for the A/B/C datapath round-robin arbiter:
//   - state_t     : arbiter FSM states (IDLE / GRANT / TURN)
//   - rel_cause_t : why a grant was released (done / withdraw / timeout)
//   - release_cause() : folds the three release conditions into one cause,
//                       with done taking precedence over the other two.
// -----------------------------------------------------------------------------
package abc_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_DONE     = 2'd1,
        CAUSE_WITHDRAW = 2'd2,
        CAUSE_TIMEOUT  = 2'd3
    } rel_cause_t;

    // Done wins over everything, so a holder that finishes on its last
    // permitted cycle is not reported as timed out. A withdrawal is likewise
    // treated as a voluntary release rather than a forced one.
    function automatic rel_cause_t release_cause(
        input logic done_in,
        input logic withdraw_in,
        input logic timeout_in
    );
        rel_cause_t cause;
        if (done_in) begin
            cause = CAUSE_DONE;
        end else if (withdraw_in) begin
            cause = CAUSE_WITHDRAW;
        end else if (timeout_in) begin
            cause = CAUSE_TIMEOUT;
        end else begin
            cause = CAUSE_NONE;
        end
        return cause;
    endfunction

endpackage

// File: rtl/abc_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating priority picker. Scans req starting at ptr and
// moving upward modulo N_REQ; the first set bit wins.
// Ports:
//   req    in  N_REQ  request vector
//   ptr    in  ID_W   index with highest priority (must be < N_REQ)
//   valid  out 1      at least one request is set
//   winner out ID_W   index of the winning requester (0 when !valid)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             valid,
    output logic [ID_W-1:0]  winner
);

    // cand_idx[k] is the requester index examined at scan offset k.
    logic [ID_W-1:0]  cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_hit;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            // One extra bit so ptr+offset cannot overflow before the wrap.
            logic [ID_W:0] sum;
            assign sum          = {1'b0, ptr} + (ID_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (ID_W+1)'(N_REQ))
                                ? ID_W'(sum - (ID_W+1)'(N_REQ))
                                : sum[ID_W-1:0];
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Walk from the farthest offset back to offset 0 so the closest hit to
    // ptr is the one left standing.
    always_comb begin
        valid  = |cand_hit;
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                winner = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/abc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// abc_rr_arbiter
// Round-robin arbiter sharing the single A/B/C datapath among N_REQ
// requesters. One grant at a time, held until done, withdrawal or timeout,
// followed by one turnaround cycle before the next arbitration.
// Ports:
//   clk            in  1      system clock, rising edge
//   rst            in  1      synchronous active-high reset
//   req            in  N_REQ  level-sensitive request vector
//   done           in  1      holder finished (ignored while busy=0)
//   gnt            out N_REQ  registered one-hot grant
//   grant_id       out ID_W   registered index of the holder
//   busy           out 1      a grant is active (== |gnt)
//   timeout_pulse  out 1      one-cycle pulse after a forced release
// -----------------------------------------------------------------------------
module abc_rr_arbiter
    import abc_rr_arbiter_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4,
    parameter int ID_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy,
    output logic             timeout_pulse
);

    // Releasing when the counter reads TIMEOUT-1 caps a grant at exactly
    // TIMEOUT cycles, because the counter starts at 0 on the first cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

    state_t           state_reg,    state_next;
    logic [CNT_W-1:0] cnt_reg,      cnt_next;
    logic [ID_W-1:0]  ptr_reg,      ptr_next;
    logic [N_REQ-1:0] gnt_reg,      gnt_next;
    logic [ID_W-1:0]  grant_id_reg, grant_id_next;
    logic             tp_reg,       tp_next;

    logic             pick_valid;
    logic [ID_W-1:0]  pick_winner;
    logic [N_REQ-1:0] winner_onehot;

    logic             rel_withdraw;
    logic             rel_timeout;
    rel_cause_t       rel_cause;
    logic             release_now;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign winner_onehot[gi] = (pick_winner == ID_W'(gi));
        end
    endgenerate

    // gnt_reg is one-hot on the holder, so masking req with it tells us
    // whether the holder still wants the datapath without indexing by id.
    assign rel_withdraw = ~|(req & gnt_reg);
    assign rel_timeout  = (cnt_reg == CNT_LAST);
    assign rel_cause    = release_cause(done, rel_withdraw, rel_timeout);
    assign release_now  = (rel_cause != CAUSE_NONE);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            ptr_reg      <= '0;
            gnt_reg      <= '0;
            grant_id_reg <= '0;
            tp_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            ptr_reg      <= ptr_next;
            gnt_reg      <= gnt_next;
            grant_id_reg <= grant_id_next;
            tp_reg       <= tp_next;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_valid)  state_next = GRANT;
            GRANT:   if (release_now) state_next = TURN;
            TURN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs / datapath
    // Computes the values the registered outputs take at the next edge.
    always_comb begin
        gnt_next      = gnt_reg;
        grant_id_next = grant_id_reg;
        cnt_next      = cnt_reg;
        ptr_next      = ptr_reg;
        tp_next       = 1'b0;
        case (state_reg)
            IDLE: begin
                gnt_next = '0;
                if (pick_valid) begin
                    gnt_next      = winner_onehot;
                    grant_id_next = pick_winner;
                    cnt_next      = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    gnt_next = '0;
                    ptr_next = (grant_id_reg == ID_LAST) ? '0 : grant_id_reg + ID_W'(1);
                    tp_next  = (rel_cause == CAUSE_TIMEOUT);
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            TURN: begin
                gnt_next = '0;
            end
            default: begin
                gnt_next = '0;
            end
        endcase
    end

    assign gnt           = gnt_reg;
    assign grant_id      = grant_id_reg;
    assign busy          = |gnt_reg;
    assign timeout_pulse = tp_reg;

endmodule

// File: tb/tb_abc_rr_arbiter.sv
module tb_abc_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic       done;
    logic [2:0] gnt;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout_pulse;

    int compared;
    int mismatched;

    abc_rr_arbiter #(
        .N_REQ   (3),
        .TIMEOUT (15),
        .CNT_W   (4),
        .ID_W    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .done          (done),
        .gnt           (gnt),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns at a falling edge with the reset edge already applied.
    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        req  = 3'b000;
        done = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req = 3'b000; done = 1'b0;
        @(negedge clk);
        compared++;
        if (gnt !== 3'b000 || busy !== 1'b0 || grant_id !== 2'd0 || timeout_pulse !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: gnt=%b busy=%b id=%0d tp=%b expected 000 0 0 0", gnt, busy, grant_id, timeout_pulse);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared++;
            if (gnt !== 3'b000 || busy !== 1'b0 || grant_id !== 2'd0) begin
                mismatched++;
                $display("FAIL idle_no_req[%0d]: gnt=%b busy=%b id=%0d expected 000 0 0", i, gnt, busy, grant_id);
            end
        end
        $display("test_reset: idle for 5 cycles");
    endtask

    task automatic test_two_req();
        do_reset();
        req = 3'b101;
        @(negedge clk);
        compared++;
        if (gnt !== 3'b001 || grant_id !== 2'd0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL first_grant: gnt=%b id=%0d busy=%b expected 001 0 1", gnt, grant_id, busy);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        compared++;
        if (gnt !== 3'b000 || busy !== 1'b0 || timeout_pulse !== 1'b0) begin
            mismatched++;
            $display("FAIL done_release: gnt=%b busy=%b tp=%b expected 000 0 0", gnt, busy, timeout_pulse);
        end
        @(negedge clk);
        compared++;
        if (gnt !== 3'b000) begin
            mismatched++;
            $display("FAIL turn_gap: gnt=%b expected 000", gnt);
        end
        @(negedge clk);
        compared++;
        if (gnt !== 3'b100 || grant_id !== 2'd2 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL second_grant: gnt=%b id=%0d busy=%b expected 100 2 1", gnt, grant_id, busy);
        end
        $display("test_two_req: grants 0 then 2");
        req = 3'b000;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_gnt [4];
        logic [1:0] exp_id  [4];
        exp_gnt[0] = 3'b001; exp_id[0] = 2'd0;
        exp_gnt[1] = 3'b010; exp_id[1] = 2'd1;
        exp_gnt[2] = 3'b100; exp_id[2] = 2'd2;
        exp_gnt[3] = 3'b001; exp_id[3] = 2'd0;
        do_reset();
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            compared++;
            if (gnt !== exp_gnt[k] || grant_id !== exp_id[k] || busy !== 1'b1) begin
                mismatched++;
                $display("FAIL rr_grant[%0d]: gnt=%b id=%0d busy=%b expected %b %0d 1", k, gnt, grant_id, busy, exp_gnt[k], exp_id[k]);
            end
            @(negedge clk);
            compared++;
            if (gnt !== exp_gnt[k]) begin
                mismatched++;
                $display("FAIL rr_hold[%0d]: gnt=%b expected %b", k, gnt, exp_gnt[k]);
            end
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            compared++;
            if (gnt !== 3'b000 || busy !== 1'b0 || timeout_pulse !== 1'b0) begin
                mismatched++;
                $display("FAIL rr_gap1[%0d]: gnt=%b busy=%b tp=%b expected 000 0 0", k, gnt, busy, timeout_pulse);
            end
            @(negedge clk);
            compared++;
            if (gnt !== 3'b000 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL rr_gap2[%0d]: gnt=%b busy=%b expected 000 0", k, gnt, busy);
            end
            $display("test_round_robin: grant %0d to requester %0d", k, exp_id[k]);
        end
        req = 3'b000;
    endtask

    task automatic test_timeout();
        do_reset();
        req = 3'b010;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            compared++;
            if (gnt !== 3'b010 || timeout_pulse !== 1'b0) begin
                mismatched++;
                $display("FAIL to_hold[%0d]: gnt=%b tp=%b expected 010 0", i, gnt, timeout_pulse);
            end
        end
        @(negedge clk);
        compared++;
        if (gnt !== 3'b000 || timeout_pulse !== 1'b1 || grant_id !== 2'd1) begin
            mismatched++;
            $display("FAIL to_release: gnt=%b tp=%b id=%0d expected 000 1 1", gnt, timeout_pulse, grant_id);
        end
        @(negedge clk);
        compared++;
        if (gnt !== 3'b000 || timeout_pulse !== 1'b0) begin
            mismatched++;
            $display("FAIL to_pulse_width: gnt=%b tp=%b expected 000 0", gnt, timeout_pulse);
        end
        @(negedge clk);
        compared++;
        if (gnt !== 3'b010 || grant_id !== 2'd1) begin
            mismatched++;
            $display("FAIL to_regrant: gnt=%b id=%0d expected 010 1", gnt, grant_id);
        end
        $display("test_timeout: 15-cycle grant, pulse, re-grant to 1");
        req = 3'b000;
    endtask

    task automatic test_done_wins();
        do_reset();
        req = 3'b010;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
        end
        // Last permitted cycle: done coincides with the timeout condition.
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        compared++;
        if (gnt !== 3'b000 || timeout_pulse !== 1'b0) begin
            mismatched++;
            $display("FAIL done_beats_timeout: gnt=%b tp=%b expected 000 0", gnt, timeout_pulse);
        end
        $display("test_done_wins: no pulse when done meets timeout");
        req = 3'b000;
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 3'b001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if (gnt !== 3'b001) begin
                mismatched++;
                $display("FAIL wd_hold[%0d]: gnt=%b expected 001", i, gnt);
            end
        end
        req = 3'b000;
        @(negedge clk);
        compared++;
        if (gnt !== 3'b000 || busy !== 1'b0 || timeout_pulse !== 1'b0) begin
            mismatched++;
            $display("FAIL wd_release: gnt=%b busy=%b tp=%b expected 000 0 0", gnt, busy, timeout_pulse);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            compared++;
            if (gnt !== 3'b000 || timeout_pulse !== 1'b0) begin
                mismatched++;
                $display("FAIL wd_after[%0d]: gnt=%b tp=%b expected 000 0", i, gnt, timeout_pulse);
            end
        end
        $display("test_withdraw: requester 0 withdrew after 3 cycles");
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 3'b100;
        // Eight edges: grant at the first, counter reads 7 after the eighth.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
        end
        compared++;
        if (gnt !== 3'b100 || grant_id !== 2'd2) begin
            mismatched++;
            $display("FAIL mid_pre: gnt=%b id=%0d expected 100 2", gnt, grant_id);
        end
        rst = 1'b1;
        req = 3'b111;
        @(negedge clk);
        rst = 1'b0;
        compared++;
        if (gnt !== 3'b000 || busy !== 1'b0 || timeout_pulse !== 1'b0 || grant_id !== 2'd0) begin
            mismatched++;
            $display("FAIL mid_reset: gnt=%b busy=%b tp=%b id=%0d expected 000 0 0 0", gnt, busy, timeout_pulse, grant_id);
        end
        @(negedge clk);
        compared++;
        if (gnt !== 3'b001 || grant_id !== 2'd0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_regrant: gnt=%b id=%0d busy=%b expected 001 0 1", gnt, grant_id, busy);
        end
        $display("test_reset_mid_grant: pointer back to 0");
        req = 3'b000;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst  = 1'b1;
        req  = 3'b000;
        done = 1'b0;
        test_reset();
        test_two_req();
        test_round_robin();
        test_timeout();
        test_done_wins();
        test_withdraw();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
